// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and types for the TDM frame collector
package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = $clog2(SLOTS);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_e;

  typedef logic [SLOTS-1:0] frame_t;

endpackage

// File: rtl/tdm_frame_collector_if.sv
// rtl/tdm_frame_collector_if.sv - serial sample input and assembled-frame output port bundle
interface tdm_frame_collector_if #(
  parameter int SLOTS = tdm_pkg::SLOTS
);
  localparam int IDX_W = $clog2(SLOTS);

  logic             serial_in;
  logic [IDX_W-1:0] slot_idx;
  logic             in_en;
  logic [SLOTS-1:0] frame_data;
  logic             frame_valid;
  logic             frame_ready;

  modport master (
    output serial_in, slot_idx, in_en, frame_ready,
    input  frame_data, frame_valid
  );

  modport slave (
    input  serial_in, slot_idx, in_en, frame_ready,
    output frame_data, frame_valid
  );

endinterface

// File: rtl/tdm_frame_collector_fifo2.sv
// rtl/tdm_frame_collector_fifo2.sv - two-entry FIFO; push on a full FIFO is taken only with a same-cycle pop
module frame_fifo2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tdm_frame_collector.sv
// rtl/tdm_frame_collector.sv - reassembles slot-indexed serial bits into parallel frames behind a 2-deep FIFO
module tdm_frame_collector
  import tdm_pkg::*;
#(
  parameter int SLOTS = tdm_pkg::SLOTS,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tdm_frame_collector_if.slave bus,
  output logic                 overflow,
  output logic                 seq_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int IDX_W = $clog2(SLOTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SLOTS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] exp_q, exp_d;
  logic [SLOTS-1:0] shreg_q, shreg_d;
  logic             seq_err_q, seq_err_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SLOTS-1:0] word, push_data, head;
  logic [SLOTS-1:0] start_word;
  logic             push, push_ok, pop_fire;
  logic             fifo_full, fifo_empty;

  assign start_word = {{(SLOTS-1){1'b0}}, bus.serial_in};

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    shreg_d       = shreg_q;
    seq_err_d     = 1'b0;
    push          = 1'b0;
    push_data     = '0;
    word          = shreg_q;
    word[exp_q]   = bus.serial_in;

    unique case (state_q)
      HUNT: begin
        if (bus.in_en && bus.slot_idx == '0) begin
          shreg_d = start_word;
          exp_d   = IDX_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_en) begin
          if (bus.slot_idx == exp_q) begin
            if (exp_q == LAST) begin
              push      = 1'b1;
              push_data = word;
              exp_d     = '0;
              shreg_d   = '0;
            end else begin
              shreg_d = word;
              exp_d   = exp_q + IDX_W'(1);
            end
          end else begin
            // A stray slot 0 is a plausible new frame start, so keep it rather than re-hunting.
            seq_err_d = 1'b1;
            if (bus.slot_idx == '0) begin
              shreg_d = start_word;
              exp_d   = IDX_W'(1);
            end else begin
              shreg_d = '0;
              exp_d   = '0;
              state_d = HUNT;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign pop_fire = !fifo_empty && bus.frame_ready;
  assign push_ok  = push && (!fifo_full || pop_fire);
  assign ovf_d    = ovf_q | (push && fifo_full && !pop_fire);
  assign cnt_d    = push_ok ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      shreg_q   <= '0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      shreg_q   <= shreg_d;
      seq_err_q <= seq_err_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  frame_fifo2 #(.W(SLOTS)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (bus.frame_ready),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.frame_data  = head;
  assign bus.frame_valid = !fifo_empty;
  assign overflow        = ovf_q;
  assign seq_err         = seq_err_q;
  assign frame_cnt       = cnt_q;

endmodule

// File: tb/tb_tdm_frame_collector.sv
// tb/tb_tdm_frame_collector.sv - scoreboard bench for tdm_frame_collector
module tb_tdm_frame_collector;
  import tdm_pkg::*;

  localparam int SL = 4;
  localparam int CW = 4;
  localparam int IW = $clog2(SL);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          overflow, seq_err;
  logic [CW-1:0] frame_cnt;

  tdm_frame_collector_if #(.SLOTS(SL)) bus ();

  tdm_frame_collector #(.SLOTS(SL), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .overflow  (overflow),
    .seq_err   (seq_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  // Reference model: expected FIFO contents, occupancy and flags
  logic [SL-1:0] sb[$];
  int            occ;
  bit            synced;
  bit            bits_q[$];
  bit            exp_seq, exp_ovf;
  int            exp_cnt;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    bits_q.delete();
    occ     = 0;
    synced  = 0;
    exp_seq = 0;
    exp_ovf = 0;
    exp_cnt = 0;
  endtask

  task automatic model_edge(bit en, int slot, bit d, bit rdy);
    bit            pop;
    bit            done;
    logic [SL-1:0] w;
    pop     = (occ > 0) && rdy;
    done    = 0;
    w       = '0;
    exp_seq = 0;
    if (en) begin
      if (!synced) begin
        if (slot == 0) begin
          synced = 1;
          bits_q.push_back(d);
        end
      end else if (slot == bits_q.size()) begin
        bits_q.push_back(d);
        if (bits_q.size() == SL) begin
          done = 1;
          foreach (bits_q[k]) if (bits_q[k]) w[k] = 1'b1;
          bits_q.delete();
        end
      end else begin
        exp_seq = 1;
        bits_q.delete();
        if (slot == 0) bits_q.push_back(d);
        else synced = 0;
      end
    end
    if (done) begin
      if (occ < 2 || pop) begin
        sb.push_back(w);
        occ++;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end else begin
        exp_ovf = 1;
      end
    end
    if (pop) occ--;
  endtask

  task automatic step(bit en, int slot, bit d, bit rdy);
    bus.in_en       = en;
    bus.slot_idx    = IW'(slot);
    bus.serial_in   = d;
    bus.frame_ready = rdy;
    @(posedge clk);
    model_edge(en, slot, d, rdy);
    #1;
  endtask

  task automatic send_frame(logic [SL-1:0] w, bit rdy);
    for (int k = 0; k < SL; k++) step(1, k, w[k], rdy);
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) step(0, 0, 0, rdy);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"}, bus.frame_valid, 0);
    check({tag, "_data"}, bus.frame_data, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("frame_valid", bus.frame_valid, sb.size() != 0);
      if (bus.frame_valid && sb.size() != 0) begin
        check("frame_data", bus.frame_data, sb[0]);
        if (bus.frame_ready) void'(sb.pop_front());
      end else if (!bus.frame_valid) begin
        check("empty_data", bus.frame_data, 0);
      end
      check("seq_err", seq_err, exp_seq);
      check("overflow", overflow, exp_ovf);
      check("frame_cnt", frame_cnt, exp_cnt);
    end
  end

  initial begin
    int  src;
    bit  en, d, rdy;
    int  slot;
    bus.in_en       = 0;
    bus.slot_idx    = '0;
    bus.serial_in   = 0;
    bus.frame_ready = 0;
    model_reset();
    #2 reset = 1'b1;
    #1 check_all_zero("init_reset");
    @(negedge clk);
    #1 reset = 1'b0;
    mon_en = 1;

    // nominal frame: serial 1,0,1,1 on slots 0..3
    step(1, 0, 1, 1); step(1, 1, 0, 1); step(1, 2, 1, 1); step(1, 3, 1, 1);
    check("nominal_word", bus.frame_data, 4'b1101);
    check("nominal_cnt", frame_cnt, 1);
    idle(2, 1);

    // broken sequence 0,1,3 then a clean 0,1,1,0 frame
    step(1, 0, 1, 1); step(1, 1, 1, 1); step(1, 3, 1, 1);
    send_frame(4'b0110, 1);
    check("recover_word", bus.frame_data, 4'b0110);
    idle(2, 1);

    // force HUNT, ignored slots 2,3, then restart on second slot 0
    step(1, 2, 0, 1); step(0, 0, 0, 1);
    step(1, 2, 1, 1); step(1, 3, 1, 1);
    step(1, 0, 0, 1); step(1, 1, 1, 1);
    step(1, 0, 1, 1); step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 1, 1);
    idle(3, 1);

    // full FIFO with pop on the completion edge
    send_frame(4'hA, 0);
    send_frame(4'hB, 0);
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 2, 1, 0); step(1, 3, 1, 1);
    idle(4, 1);

    // backpressure: third frame dropped
    send_frame(4'h1, 0);
    send_frame(4'h2, 0);
    send_frame(4'h3, 0);
    check("bp_overflow", overflow, 1);
    idle(4, 1);

    // reset mid-traffic with a full FIFO entry and a partial frame
    send_frame(4'h5, 0);
    step(1, 0, 1, 0); step(1, 1, 1, 0);
    do_reset();

    // random traffic, mostly well-sequenced with occasional stray slots and gaps
    src = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      en   = ($urandom_range(0, 9) < 8);
      slot = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, SL - 1)) : src;
      if (en) src = (slot + 1) % SL;
      d    = 1'($urandom);
      rdy  = (i < 1500) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
      step(en, slot, d, rdy);
    end

    idle(8, 1);
    check("drain_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
